axi_rd_wr_arbiter: RTL and testbench

- Shares the core's single AXI4 master port between two requesters: IFU (m0, read-only) and LSU (m1, read and write).
- Its downstream port drives the address-decoding crossbar that splits traffic to CLNT and SOC.
- Reads are arbitrated round-robin with one outstanding burst at a time. Writes come from LSU only and are sequenced one transaction at a time.

---
 rtl/axi_rd_wr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_axi_rd_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_wr_arbiter.sv
// axi_rd_wr_arbiter
// -----------------------------------------------------------------------------
// Shares the core's single AXI4 master port between the IFU (m0, read only)
// and the LSU (m1, read and write). The downstream s_* port feeds the address
// crossbar.
//
// Reads : round-robin between m0 and m1, one outstanding burst at a time.
//         The AR payload is registered in RD_IDLE and presented on s_ar* from
//         RD_ADDR. R beats are routed combinationally to the granted side in
//         RD_DATA.
// Writes: LSU only, one transaction at a time. AW is registered. W and B pass
//         through combinationally in WR_DATA and WR_RESP. Writes run
//         independently of reads.
//
// Handshake rule on every channel: a beat transfers on the rising clock edge
// where valid and ready are both 1. A source holds valid and payload stable
// until that edge and may not wait for ready before raising valid.
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   m0_ar*, m0_r*           IFU read address / read data channels
//   m1_ar*, m1_r*           LSU read address / read data channels
//   m1_aw*, m1_w*, m1_b*    LSU write address / write data / write response
//   s_ar*, s_r*, s_aw*,
//   s_w*, s_b*              downstream AXI4 port toward the crossbar
//   dbg_rd_state            read FSM state  (0 idle, 1 addr, 2 data)
//   dbg_wr_state            write FSM state (0 idle, 1 addr, 2 data, 3 resp)
//   dbg_gnt                 current read grant (0 = m0, 1 = m1)
//   dbg_rr_ptr              requester preferred on the next read tie
// -----------------------------------------------------------------------------
module axi_rd_wr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                clock,
   input  logic                reset,
   // IFU read
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [ID_W-1:0]     m0_arid,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [ADDR_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic [ID_W-1:0]     m0_rid,
   output logic                m0_rlast,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // LSU read
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [ID_W-1:0]     m1_arid,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [ADDR_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic [ID_W-1:0]     m1_rid,
   output logic                m1_rlast,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   // LSU write
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [ADDR_W-1:0]   m1_wdata,
   input  logic [ADDR_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic [ID_W-1:0]     m1_bid,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   // Downstream port
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [ID_W-1:0]     s_arid,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [ADDR_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic [ID_W-1:0]     s_rid,
   input  logic                s_rlast,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [ID_W-1:0]     s_awid,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [ADDR_W-1:0]   s_wdata,
   output logic [ADDR_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic [ID_W-1:0]     s_bid,
   input  logic                s_bvalid,
   output logic                s_bready,
   // Debug visibility
   output logic [1:0]          dbg_rd_state,
   output logic [1:0]          dbg_wr_state,
   output logic                dbg_gnt,
   output logic                dbg_rr_ptr
);

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_DATA = 2'd2,
      WR_RESP = 2'd3
   } wr_state_t;

   rd_state_t rd_state, rd_next;
   wr_state_t wr_state, wr_next;

   logic              gnt;
   logic              rr_ptr;
   logic [ADDR_W-1:0] ar_addr_q;
   logic [ID_W-1:0]   ar_id_q;
   logic [7:0]        ar_len_q;
   logic [2:0]        ar_size_q;
   logic [1:0]        ar_burst_q;

   logic [ADDR_W-1:0] aw_addr_q;
   logic [ID_W-1:0]   aw_id_q;
   logic [7:0]        aw_len_q;
   logic [2:0]        aw_size_q;
   logic [1:0]        aw_burst_q;

   // Read arbitration: a tie goes to rr_ptr, otherwise to whoever is asking.
   logic any_arvalid;
   logic both_arvalid;
   logic win;
   logic rd_capture;

   assign any_arvalid  = m0_arvalid | m1_arvalid;
   assign both_arvalid = m0_arvalid & m1_arvalid;
   assign win          = both_arvalid ? rr_ptr : m1_arvalid;
   assign rd_capture   = (rd_state == RD_IDLE) && any_arvalid;

   // ---------------------------------------------------------------- read FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_state   <= RD_IDLE;
         gnt        <= 1'b0;
         rr_ptr     <= 1'b0;
         ar_addr_q  <= '0;
         ar_id_q    <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
      end else begin
         rd_state <= rd_next;
         if (rd_capture) begin
            gnt <= win;
            // Only a contested grant moves the pointer.
            if (both_arvalid) rr_ptr <= ~win;
            ar_addr_q  <= win ? m1_araddr  : m0_araddr;
            ar_id_q    <= win ? m1_arid    : m0_arid;
            ar_len_q   <= win ? m1_arlen   : m0_arlen;
            ar_size_q  <= win ? m1_arsize  : m0_arsize;
            ar_burst_q <= win ? m1_arburst : m0_arburst;
         end
      end
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE: if (any_arvalid) rd_next = RD_ADDR;
         RD_ADDR: if (s_arready) rd_next = RD_DATA;
         RD_DATA: if (s_rvalid && s_rready && s_rlast) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_arsize   = '0;
      s_arburst  = '0;
      s_rready   = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rid     = '0;
      m0_rlast   = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rid     = '0;
      m1_rlast   = 1'b0;

      // The arready pulse is combinational off arvalid, so it must also be
      // masked while reset is held.
      if (rd_capture && !reset) begin
         m0_arready = ~win;
         m1_arready = win;
      end

      if (rd_state == RD_ADDR) begin
         s_arvalid = 1'b1;
         s_araddr  = ar_addr_q;
         s_arid    = ar_id_q;
         s_arlen   = ar_len_q;
         s_arsize  = ar_size_q;
         s_arburst = ar_burst_q;
      end

      if (rd_state == RD_DATA) begin
         if (!gnt) begin
            s_rready  = m0_rready;
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            m0_rid    = s_rid;
            m0_rlast  = s_rlast;
         end else begin
            s_rready  = m1_rready;
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            m1_rid    = s_rid;
            m1_rlast  = s_rlast;
         end
      end
   end

   // --------------------------------------------------------------- write FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_state   <= WR_IDLE;
         aw_addr_q  <= '0;
         aw_id_q    <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
      end else begin
         wr_state <= wr_next;
         if ((wr_state == WR_IDLE) && m1_awvalid) begin
            aw_addr_q  <= m1_awaddr;
            aw_id_q    <= m1_awid;
            aw_len_q   <= m1_awlen;
            aw_size_q  <= m1_awsize;
            aw_burst_q <= m1_awburst;
         end
      end
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: if (m1_awvalid) wr_next = WR_ADDR;
         WR_ADDR: if (s_awready) wr_next = WR_DATA;
         WR_DATA: if (m1_wvalid && s_wready && m1_wlast) wr_next = WR_RESP;
         WR_RESP: if (s_bvalid && m1_bready) wr_next = WR_IDLE;
         default: wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      m1_awready = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = '0;
      s_awid     = '0;
      s_awlen    = '0;
      s_awsize   = '0;
      s_awburst  = '0;
      m1_wready  = 1'b0;
      s_wvalid   = 1'b0;
      s_wdata    = '0;
      s_wstrb    = '0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = '0;
      m1_bid     = '0;

      if ((wr_state == WR_IDLE) && m1_awvalid && !reset) m1_awready = 1'b1;

      if (wr_state == WR_ADDR) begin
         s_awvalid = 1'b1;
         s_awaddr  = aw_addr_q;
         s_awid    = aw_id_q;
         s_awlen   = aw_len_q;
         s_awsize  = aw_size_q;
         s_awburst = aw_burst_q;
      end

      // W beats offered before WR_DATA simply see wready=0 and wait.
      if (wr_state == WR_DATA) begin
         m1_wready = s_wready;
         s_wvalid  = m1_wvalid;
         if (m1_wvalid) begin
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
            s_wlast = m1_wlast;
         end
      end

      if (wr_state == WR_RESP) begin
         s_bready  = m1_bready;
         m1_bvalid = s_bvalid;
         m1_bresp  = s_bresp;
         m1_bid    = s_bid;
      end
   end

   assign dbg_rd_state = rd_state;
   assign dbg_wr_state = wr_state;
   assign dbg_gnt      = gnt;
   assign dbg_rr_ptr   = rr_ptr;

endmodule

// File: tb/tb_axi_rd_wr_arbiter.sv
// Directed bench for axi_rd_wr_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled a further time unit later.
module tb_axi_rd_wr_arbiter;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_ADDR = 2'd1;
   localparam logic [1:0] RD_DATA = 2'd2;
   localparam logic [1:0] WR_IDLE = 2'd0;
   localparam logic [1:0] WR_ADDR = 2'd1;
   localparam logic [1:0] WR_DATA = 2'd2;
   localparam logic [1:0] WR_RESP = 2'd3;

   logic clock, reset;
   logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
   logic [3:0]  m0_arid, m1_arid, m1_awid, m1_wstrb, s_rid, s_bid;
   logic [7:0]  m0_arlen, m1_arlen, m1_awlen;
   logic [2:0]  m0_arsize, m1_arsize, m1_awsize;
   logic [1:0]  m0_arburst, m1_arburst, m1_awburst, s_rresp, s_bresp;
   logic m0_arvalid, m1_arvalid, m0_rready, m1_rready, m1_awvalid, m1_wlast;
   logic m1_wvalid, m1_bready, s_arready, s_rlast, s_rvalid, s_awready;
   logic s_wready, s_bvalid;

   logic        m0_arready, m1_arready, m0_rlast, m0_rvalid, m1_rlast, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
   logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst;
   logic [3:0]  m0_rid, m1_rid, m1_bid, s_arid, s_awid, s_wstrb;
   logic        m1_awready, m1_wready, m1_bvalid;
   logic [7:0]  s_arlen, s_awlen;
   logic [2:0]  s_arsize, s_awsize;
   logic        s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
   logic [1:0]  dbg_rd_state, dbg_wr_state;
   logic        dbg_gnt, dbg_rr_ptr;

   int tests_run    = 0;
   int tests_failed = 0;

   axi_rd_wr_arbiter #(.ADDR_W(32), .ID_W(4)) dut (
      .clock(clock), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
      .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
      .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m0_rid(m0_rid), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
      .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
      .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_rid(m1_rid), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
      .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid),
      .m1_awready(m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bid(m1_bid), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid),
      .s_bready(s_bready),
      .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state),
      .dbg_gnt(dbg_gnt), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // ------------------------------------------------------ clock and reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic init_inputs();
      m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
      m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1;
      m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
      m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'd1;
      m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_wvalid = 0;
      m1_bready = 0; s_arready = 0; s_rdata = '0; s_rresp = '0; s_rid = '0;
      s_rlast = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bresp = '0;
      s_bid = '0; s_bvalid = 0;
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1;
      #1;
      if (m0_arready !== 1'b0) begin tests_failed++; $display("FAIL reset_m0_arready got=%0h exp=0", m0_arready); end tests_run++;
      if (m1_arready !== 1'b0) begin tests_failed++; $display("FAIL reset_m1_arready got=%0h exp=0", m1_arready); end tests_run++;
      if (m1_awready !== 1'b0) begin tests_failed++; $display("FAIL reset_m1_awready got=%0h exp=0", m1_awready); end tests_run++;
      if (s_arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_s_arvalid got=%0h exp=0", s_arvalid); end tests_run++;
      if (dbg_rd_state !== RD_IDLE) begin tests_failed++; $display("FAIL reset_rd_state got=%0h exp=0", dbg_rd_state); end tests_run++;
      if (dbg_wr_state !== WR_IDLE) begin tests_failed++; $display("FAIL reset_wr_state got=%0h exp=0", dbg_wr_state); end tests_run++;
      if (dbg_rr_ptr !== 1'b0) begin tests_failed++; $display("FAIL reset_rr_ptr got=%0h exp=0", dbg_rr_ptr); end tests_run++;
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_awvalid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      m0_araddr = 32'h8000_0000; m0_arid = 4'h5; m0_arlen = 8'd3; m0_arvalid = 1'b1;
      #1;
      if (m0_arready !== 1'b1) begin tests_failed++; $display("FAIL single_m0_arready got=%0h exp=1", m0_arready); end tests_run++;
      if (m1_arready !== 1'b0) begin tests_failed++; $display("FAIL single_m1_arready got=%0h exp=0", m1_arready); end tests_run++;
      if (s_arvalid !== 1'b0) begin tests_failed++; $display("FAIL single_arvalid_T got=%0h exp=0", s_arvalid); end tests_run++;
      tick();
      m0_arvalid = 1'b0;
      #1;
      if (s_arvalid !== 1'b1) begin tests_failed++; $display("FAIL single_arvalid_T1 got=%0h exp=1", s_arvalid); end tests_run++;
      if (s_araddr !== 32'h8000_0000) begin tests_failed++; $display("FAIL single_araddr got=%0h exp=80000000", s_araddr); end tests_run++;
      if (s_arlen !== 8'd3) begin tests_failed++; $display("FAIL single_arlen got=%0h exp=3", s_arlen); end tests_run++;
      if (s_arid !== 4'h5) begin tests_failed++; $display("FAIL single_arid got=%0h exp=5", s_arid); end tests_run++;
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      #1;
      if (s_araddr !== 32'h0) begin tests_failed++; $display("FAIL single_araddr_idle got=%0h exp=0", s_araddr); end tests_run++;
      for (int i = 0; i < 4; i++) begin
         s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + 32'(i); s_rlast = (i == 3);
         s_rid = 4'h5; s_rresp = 2'b00; m0_rready = 1'b1;
         #1;
         if (m0_rvalid !== 1'b1) begin tests_failed++; $display("FAIL single_m0_rvalid beat=%0d got=%0h exp=1", i, m0_rvalid); end tests_run++;
         if (m0_rdata !== 32'hA000_0000 + 32'(i)) begin tests_failed++; $display("FAIL single_m0_rdata beat=%0d got=%0h exp=%0h", i, m0_rdata, 32'hA000_0000 + 32'(i)); end tests_run++;
         if (m0_rlast !== (i == 3)) begin tests_failed++; $display("FAIL single_m0_rlast beat=%0d got=%0h", i, m0_rlast); end tests_run++;
         if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_m1_rvalid beat=%0d got=%0h exp=0", i, m1_rvalid); end tests_run++;
         if (s_rready !== 1'b1) begin tests_failed++; $display("FAIL single_s_rready beat=%0d got=%0h exp=1", i, s_rready); end tests_run++;
         tick();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
      #1;
      if (dbg_rd_state !== RD_IDLE) begin tests_failed++; $display("FAIL single_end_state got=%0h exp=0", dbg_rd_state); end tests_run++;
   endtask

   task automatic test_back_to_back();
      logic exp_g;
      m0_araddr = 32'h0000_1000; m0_arid = 4'h1; m0_arlen = 8'd0;
      m1_araddr = 32'h0000_2000; m1_arid = 4'h2; m1_arlen = 8'd0;
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         exp_g = (b == 1);
         #1;
         if (m0_arready !== !exp_g) begin tests_failed++; $display("FAIL b2b_m0_arready burst=%0d got=%0h exp=%0h", b, m0_arready, !exp_g); end tests_run++;
         if (m1_arready !== exp_g) begin tests_failed++; $display("FAIL b2b_m1_arready burst=%0d got=%0h exp=%0h", b, m1_arready, exp_g); end tests_run++;
         if (s_arvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_gap burst=%0d got=%0h exp=0", b, s_arvalid); end tests_run++;
         tick();
         s_arready = 1'b1;
         #1;
         if (s_arvalid !== 1'b1) begin tests_failed++; $display("FAIL b2b_arvalid burst=%0d got=%0h exp=1", b, s_arvalid); end tests_run++;
         if (s_arid !== (exp_g ? 4'h2 : 4'h1)) begin tests_failed++; $display("FAIL b2b_arid burst=%0d got=%0h exp=%0h", b, s_arid, exp_g ? 4'h2 : 4'h1); end tests_run++;
         if (s_araddr !== (exp_g ? 32'h2000 : 32'h1000)) begin tests_failed++; $display("FAIL b2b_araddr burst=%0d got=%0h", b, s_araddr); end tests_run++;
         tick();
         s_arready = 1'b0;
         s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hB0 + 32'(b); s_rid = exp_g ? 4'h2 : 4'h1;
         #1;
         if (m0_rvalid !== !exp_g) begin tests_failed++; $display("FAIL b2b_m0_rvalid burst=%0d got=%0h exp=%0h", b, m0_rvalid, !exp_g); end tests_run++;
         if (m1_rvalid !== exp_g) begin tests_failed++; $display("FAIL b2b_m1_rvalid burst=%0d got=%0h exp=%0h", b, m1_rvalid, exp_g); end tests_run++;
         tick();
         s_rvalid = 1'b0; s_rlast = 1'b0;
         if (b == 2) begin m0_arvalid = 1'b0; m1_arvalid = 1'b0; end
      end
      #1;
      if (dbg_rd_state !== RD_IDLE) begin tests_failed++; $display("FAIL b2b_end_state got=%0h exp=0", dbg_rd_state); end tests_run++;
      if (dbg_rr_ptr !== 1'b1) begin tests_failed++; $display("FAIL b2b_rr_ptr got=%0h exp=1", dbg_rr_ptr); end tests_run++;
      m0_rready = 1'b0; m1_rready = 1'b0;
      tick();
   endtask

   task automatic test_ar_stall();
      m1_araddr = 32'h1234_5678; m1_arid = 4'hA; m1_arlen = 8'd7; m1_arvalid = 1'b1;
      #1;
      if (m1_arready !== 1'b1) begin tests_failed++; $display("FAIL stall_m1_arready got=%0h exp=1", m1_arready); end tests_run++;
      tick();
      m1_arvalid = 1'b0; m1_araddr = 32'hFFFF_FFFF; m1_arid = 4'h0; m1_arlen = 8'd0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (s_arvalid !== 1'b1) begin tests_failed++; $display("FAIL stall_arvalid cyc=%0d got=%0h exp=1", c, s_arvalid); end tests_run++;
         if (s_araddr !== 32'h1234_5678) begin tests_failed++; $display("FAIL stall_araddr cyc=%0d got=%0h exp=12345678", c, s_araddr); end tests_run++;
         if (s_arid !== 4'hA) begin tests_failed++; $display("FAIL stall_arid cyc=%0d got=%0h exp=a", c, s_arid); end tests_run++;
         if (s_arlen !== 8'd7) begin tests_failed++; $display("FAIL stall_arlen cyc=%0d got=%0h exp=7", c, s_arlen); end tests_run++;
         tick();
      end
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      #1;
      if (dbg_rd_state !== RD_DATA) begin tests_failed++; $display("FAIL stall_to_data got=%0h exp=2", dbg_rd_state); end tests_run++;
      // The arbiter tracks only rlast, so a single closing beat ends the burst.
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'hA; m1_rready = 1'b1;
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0; m1_rready = 1'b0;
      tick();
   endtask

   task automatic test_rresp_error();
      m1_araddr = 32'h0000_4000; m1_arid = 4'h3; m1_arlen = 8'd1; m1_arvalid = 1'b1;
      tick();
      m1_arvalid = 1'b0; s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m1_rready = 1'b1;
      s_rvalid = 1'b1; s_rlast = 1'b0; s_rresp = 2'b00; s_rid = 4'h3; s_rdata = 32'h1111_1111;
      #1;
      if (m1_rresp !== 2'b00) begin tests_failed++; $display("FAIL err_rresp_beat0 got=%0h exp=0", m1_rresp); end tests_run++;
      tick();
      s_rlast = 1'b1; s_rresp = 2'b10; s_rdata = 32'h2222_2222;
      #1;
      if (m1_rvalid !== 1'b1) begin tests_failed++; $display("FAIL err_rvalid got=%0h exp=1", m1_rvalid); end tests_run++;
      if (m1_rresp !== 2'b10) begin tests_failed++; $display("FAIL err_rresp got=%0h exp=2", m1_rresp); end tests_run++;
      if (m1_rid !== 4'h3) begin tests_failed++; $display("FAIL err_rid got=%0h exp=3", m1_rid); end tests_run++;
      if (m1_rlast !== 1'b1) begin tests_failed++; $display("FAIL err_rlast got=%0h exp=1", m1_rlast); end tests_run++;
      if (m0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL err_m0_rvalid got=%0h exp=0", m0_rvalid); end tests_run++;
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00; m1_rready = 1'b0;
      #1;
      if (dbg_rd_state !== RD_IDLE) begin tests_failed++; $display("FAIL err_end_state got=%0h exp=0", dbg_rd_state); end tests_run++;
      tick();
   endtask

   task automatic test_write();
      m1_awaddr = 32'h0200_0000; m1_awid = 4'h6; m1_awlen = 8'd1; m1_awvalid = 1'b1;
      m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1'b0;
      s_wready = 1'b1;
      #1;
      if (m1_awready !== 1'b1) begin tests_failed++; $display("FAIL wr_awready got=%0h exp=1", m1_awready); end tests_run++;
      if (m1_wready !== 1'b0) begin tests_failed++; $display("FAIL wr_wready_idle got=%0h exp=0", m1_wready); end tests_run++;
      if (s_wvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_s_wvalid_idle got=%0h exp=0", s_wvalid); end tests_run++;
      tick();
      m1_awvalid = 1'b0; m1_awaddr = 32'h0;
      #1;
      if (dbg_wr_state !== WR_ADDR) begin tests_failed++; $display("FAIL wr_state_addr got=%0h exp=1", dbg_wr_state); end tests_run++;
      if (s_awvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_awvalid got=%0h exp=1", s_awvalid); end tests_run++;
      if (s_awaddr !== 32'h0200_0000) begin tests_failed++; $display("FAIL wr_awaddr got=%0h exp=2000000", s_awaddr); end tests_run++;
      if (s_awlen !== 8'd1) begin tests_failed++; $display("FAIL wr_awlen got=%0h exp=1", s_awlen); end tests_run++;
      if (m1_wready !== 1'b0) begin tests_failed++; $display("FAIL wr_wready_addr got=%0h exp=0", m1_wready); end tests_run++;
      if (s_wvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_s_wvalid_addr got=%0h exp=0", s_wvalid); end tests_run++;
      s_awready = 1'b1;
      tick();
      s_awready = 1'b0;
      #1;
      if (s_awvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_awvalid_drop got=%0h exp=0", s_awvalid); end tests_run++;
      if (s_wvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_beat0_wvalid got=%0h exp=1", s_wvalid); end tests_run++;
      if (s_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_beat0_wdata got=%0h exp=deadbeef", s_wdata); end tests_run++;
      if (m1_wready !== 1'b1) begin tests_failed++; $display("FAIL wr_beat0_wready got=%0h exp=1", m1_wready); end tests_run++;
      tick();
      m1_wdata = 32'h1234_5678; m1_wlast = 1'b1;
      #1;
      if (s_wdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL wr_beat1_wdata got=%0h exp=12345678", s_wdata); end tests_run++;
      if (s_wlast !== 1'b1) begin tests_failed++; $display("FAIL wr_beat1_wlast got=%0h exp=1", s_wlast); end tests_run++;
      tick();
      m1_wvalid = 1'b0; m1_wlast = 1'b0;
      #1;
      if (dbg_wr_state !== WR_RESP) begin tests_failed++; $display("FAIL wr_state_resp got=%0h exp=3", dbg_wr_state); end tests_run++;
      if (m1_wready !== 1'b0) begin tests_failed++; $display("FAIL wr_wready_resp got=%0h exp=0", m1_wready); end tests_run++;
      s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h6; m1_bready = 1'b1;
      #1;
      if (m1_bvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_bvalid got=%0h exp=1", m1_bvalid); end tests_run++;
      if (m1_bid !== 4'h6) begin tests_failed++; $display("FAIL wr_bid got=%0h exp=6", m1_bid); end tests_run++;
      if (s_bready !== 1'b1) begin tests_failed++; $display("FAIL wr_s_bready got=%0h exp=1", s_bready); end tests_run++;
      tick();
      s_bvalid = 1'b0; m1_bready = 1'b0; s_wready = 1'b0;
      #1;
      if (dbg_wr_state !== WR_IDLE) begin tests_failed++; $display("FAIL wr_end_state got=%0h exp=0", dbg_wr_state); end tests_run++;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      // rr_ptr is 1 here after the earlier contested bursts.
      m0_araddr = 32'h0000_3000; m0_arid = 4'h7; m0_arlen = 8'd3; m0_arvalid = 1'b1;
      tick();
      m0_arvalid = 1'b0; s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m0_rready = 1'b1;
      s_rvalid = 1'b1; s_rlast = 1'b0; s_rid = 4'h7; s_rdata = 32'hC0;
      tick();
      s_rdata = 32'hC1;
      #1;
      if (m0_rvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre_rvalid got=%0h exp=1", m0_rvalid); end tests_run++;
      reset = 1'b1;
      #1;
      if (s_rready !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_s_rready got=%0h exp=0", s_rready); end tests_run++;
      if (s_arvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_s_arvalid got=%0h exp=0", s_arvalid); end tests_run++;
      if (m0_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_m0_rvalid got=%0h exp=0", m0_rvalid); end tests_run++;
      if (m1_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_m1_rvalid got=%0h exp=0", m1_rvalid); end tests_run++;
      if (dbg_rd_state !== RD_IDLE) begin tests_failed++; $display("FAIL rst_mid_state got=%0h exp=0", dbg_rd_state); end tests_run++;
      if (dbg_rr_ptr !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_rr_ptr got=%0h exp=0", dbg_rr_ptr); end tests_run++;
      s_rvalid = 1'b0; m0_rready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      m0_araddr = 32'h0000_5000; m0_arid = 4'h1; m0_arlen = 8'd0;
      m1_araddr = 32'h0000_6000; m1_arid = 4'h2; m1_arlen = 8'd0;
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      #1;
      if (m0_arready !== 1'b1) begin tests_failed++; $display("FAIL rst_tie_m0_arready got=%0h exp=1", m0_arready); end tests_run++;
      if (m1_arready !== 1'b0) begin tests_failed++; $display("FAIL rst_tie_m1_arready got=%0h exp=0", m1_arready); end tests_run++;
      tick();
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      #1;
      if (dbg_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_tie_gnt got=%0h exp=0", dbg_gnt); end tests_run++;
      if (s_araddr !== 32'h0000_5000) begin tests_failed++; $display("FAIL rst_tie_araddr got=%0h exp=5000", s_araddr); end tests_run++;
      if (dbg_rr_ptr !== 1'b1) begin tests_failed++; $display("FAIL rst_tie_rr_ptr got=%0h exp=1", dbg_rr_ptr); end tests_run++;
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m0_rready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = 4'h1;
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
      tick();
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      reset = 1'b1;
      init_inputs();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_ar_stall();
      test_rresp_error();
      test_write();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
